// File: rtl/pb_pkg.sv
// rtl/pb_pkg.sv - shared types and default timing for the pushbutton debouncer
package pb_pkg;

  // Long-press tracker states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    LONG = 2'd2
  } pb_state_t;

  // 10 ms and 1 s at a 50 MHz system clock
  localparam int unsigned DB_CYCLES_DFLT   = 500_000;
  localparam int unsigned LONG_CYCLES_DFLT = 50_000_000;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for an asynchronous single-bit pad
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // Two back-to-back flops give the first one a full cycle to resolve metastability
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/pb_debounce.sv
// rtl/pb_debounce.sv - mode pushbutton debouncer with edge and long-press pulses
module pb_debounce
  import pb_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = DB_CYCLES_DFLT,
  parameter int unsigned LONG_CYCLES = LONG_CYCLES_DFLT
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_raw,
  output logic pb_lvl,
  output logic pb_rise,
  output logic pb_fall,
  output logic long_press
);

  localparam int DBW = $clog2(DB_CYCLES);
  localparam int LW  = $clog2(LONG_CYCLES);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [LW-1:0]  LONG_LAST = LW'(LONG_CYCLES - 1);

  logic           pb_s;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           lvl_q, lvl_d;
  logic           lvl_dly_q;
  logic           rise_q, fall_q;
  pb_state_t      state_q, state_d;
  logic [LW-1:0]  hold_q, hold_d;
  logic           long_d;

  sync2 u_sync2 (
    .clk (clk),
    .rst (rst),
    .d_i (pb_raw),
    .q_o (pb_s)
  );

  // Count consecutive cycles the synchronized pad disagrees with the stable level
  always_comb begin
    db_cnt_d = db_cnt_q;
    lvl_d    = lvl_q;
    if (pb_s == lvl_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      lvl_d    = pb_s;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + DBW'(1);
    end
  end

  // Debounce state plus a delayed copy of the level used for edge pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt_q  <= '0;
      lvl_q     <= 1'b0;
      lvl_dly_q <= 1'b0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      lvl_q     <= lvl_d;
      lvl_dly_q <= lvl_q;
      rise_q    <= lvl_q & ~lvl_dly_q;
      fall_q    <= ~lvl_q & lvl_dly_q;
    end
  end

  // Long-press tracker state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Long-press next state; the hold counter freezes in LONG so it never wraps
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    long_d  = 1'b0;
    case (state_q)
      IDLE: begin
        hold_d = '0;
        if (lvl_q) begin
          state_d = HELD;
        end
      end
      HELD: begin
        if (!lvl_q) begin
          state_d = IDLE;
        end else if (hold_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = LONG;
        end else begin
          hold_d = hold_q + LW'(1);
        end
      end
      LONG: begin
        if (!lvl_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
  end

  assign pb_lvl     = lvl_q;
  assign pb_rise    = rise_q;
  assign pb_fall    = fall_q;
  assign long_press = long_d;

endmodule

// File: tb/tb_pb_debounce.sv
// tb/tb_pb_debounce.sv - randomized self-checking bench for pb_debounce
module tb_pb_debounce;

  localparam int DB   = 8;
  localparam int LONG = 40;
  localparam int HMAX = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pb_raw = 1'b0;
  logic pb_lvl, pb_rise, pb_fall, long_press;

  int vectors = 0;
  int errors  = 0;

  // Reference model: pad history and derived behaviour
  bit hist [0:HMAX-1];
  int n = -1;
  bit m_lvl = 0, m_rise = 0, m_fall = 0, m_long = 0;
  bit up_prev = 0, dn_prev = 0;
  int m_l = -1;

  pb_debounce #(
    .DB_CYCLES   (DB),
    .LONG_CYCLES (LONG)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pb_raw     (pb_raw),
    .pb_lvl     (pb_lvl),
    .pb_rise    (pb_rise),
    .pb_fall    (pb_fall),
    .long_press (long_press)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic obs, input logic exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0b expected %0b", tag, n, obs, exp);
    end
  endtask

  // Level flips once the synchronized pad (raw delayed two edges) has disagreed
  // with it on each of the last DB edges; long_press fires LONG edges after the rise.
  task automatic model_edge(input bit raw, input bit r);
    bit flip;
    if (r) begin
      hist[n] = 1'b0;
      m_lvl = 0; m_rise = 0; m_fall = 0; m_long = 0;
      up_prev = 0; dn_prev = 0; m_l = -1;
    end else begin
      hist[n] = raw;
      m_rise = up_prev;
      m_fall = dn_prev;
      flip = 1'b0;
      if (n >= DB + 1) begin
        flip = 1'b1;
        for (int k = n - DB - 1; k <= n - 2; k++)
          if (hist[k] == m_lvl) flip = 1'b0;
      end
      up_prev = flip && !m_lvl;
      dn_prev = flip && m_lvl;
      if (flip) m_lvl = !m_lvl;
      if (up_prev) m_l = n;
      m_long = m_lvl && (m_l >= 0) && (n - m_l == LONG);
    end
  endtask

  task automatic step(input bit raw, input bit r);
    bit asserting;
    asserting = r && !rst;
    rst    = r;
    pb_raw = raw;
    if (asserting) begin
      #1;
      check_eq("async_rst_lvl",  pb_lvl,     1'b0);
      check_eq("async_rst_rise", pb_rise,    1'b0);
      check_eq("async_rst_fall", pb_fall,    1'b0);
      check_eq("async_rst_long", long_press, 1'b0);
    end
    @(posedge clk);
    n++;
    if (n >= HMAX) begin
      $display("FAIL history_overflow: edge %0d exceeds %0d", n, HMAX);
      $fatal(1, "bench history overflow");
    end
    model_edge(raw, r);
    @(negedge clk);
    check_eq("pb_lvl",     pb_lvl,     m_lvl);
    check_eq("pb_rise",    pb_rise,    m_rise);
    check_eq("pb_fall",    pb_fall,    m_fall);
    check_eq("long_press", long_press, m_long);
  endtask

  task automatic hold(input bit raw, input int cycles);
    for (int i = 0; i < cycles; i++) step(raw, 1'b0);
  endtask

  int  len;
  bit  rval;

  initial begin
    repeat (3) step(1'b0, 1'b1);

    // Clean press, held past the long-press point, then released
    hold(1'b1, 100);
    hold(1'b0, 40);

    // Bounce toggling every 3 cycles, then settling high
    for (int i = 0; i < 10; i++) hold((i % 2) == 0, 3);
    hold(1'b1, 60);
    hold(1'b0, 30);

    // Short release glitch while held, then a long press, release and re-press
    hold(1'b1, 20);
    hold(1'b0, 7);
    hold(1'b1, 60);
    hold(1'b0, 30);
    hold(1'b1, 60);
    hold(1'b0, 30);

    // Reset pulse in the middle of a held press
    hold(1'b1, 20);
    repeat (2) step(1'b1, 1'b1);
    hold(1'b1, 60);
    hold(1'b0, 30);

    // Press shorter than the long-press time
    hold(1'b1, 25);
    hold(1'b0, 30);

    // Random runs with occasional resets
    for (int i = 0; i < 80; i++) begin
      len  = int'($urandom_range(1, 50));
      rval = bit'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) begin
        repeat (int'($urandom_range(1, 2))) step(rval, 1'b1);
      end
      hold(rval, len);
    end
    hold(1'b1, 60);
    hold(1'b0, 30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
